datapath_ctrl: RTL
==================

// Module: datapath_ctrl
// PURPOSE
//  Sequencer sitting directly upstream of the datapath; replaces manual switch stepping.
//  Accepts one command per start handshake and drives the datapath control inputs cycle by cycle.
//  Commands cover MOVI/MOV/ADD/CMP/AND/MVN. Reports ready (w) when idle.
// PARAMETERS
//  DATA_W  16  datapath width; datapath_in = {(DATA_W-IMM_W)'b0, imm}
//  IMM_W   8   immediate width
//  RN_W    3   register-number width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  s            in   1       start; sampled only in WAIT
//  op           in   3       000 MOVI,001 MOV,010 ADD,011 CMP,100 AND,101 MVN,11x illegal
//  rd,rn,rm     in   RN_W    dest / A-source / B-source register numbers
//  shift_in     in   2       shift for the B operand (MOV,ADD,CMP,AND,MVN)
//  imm          in   IMM_W   immediate for MOVI
//  w            out  1       1 = idle/ready (WAIT)
//  err          out  1       1-cycle pulse on illegal op
//  readnum      out  RN_W    datapath control
//  writenum     out  RN_W    datapath control
//  loada,loadb,asel,bsel,loadc,loads,write,vsel  out 1  datapath control
//  shift,ALUop  out  2       datapath control (ALUop 00 add,01 sub,10 and,11 ~B)
//  datapath_in  out  DATA_W  zero-extended latched imm
// BEHAVIOUR
//  Clocking/reset: one clock clk; reset synchronous active-high. Reset forces WAIT on that edge.
//   Outputs after reset: w=1, err=0, datapath_in=0. All loads, write, vsel, asel, bsel = 0.
//   readnum, writenum, shift and ALUop = 0.
//  Reset mid-command: abandon the command at the next edge. No write is issued afterward.
//  Accept: posedge with state=WAIT and s=1 latches op,rd,rn,rm,shift_in,imm into cmd regs.
//   The first state is entered on that same edge. s is ignored outside WAIT (no queuing).
//  Outputs are Moore: decoded from state + cmd regs only.
//   Inputs changing after accept have no effect.
//  Every control not listed for a state is 0.
//   Datapath registers capture at the edge that ends each state.
//  States and per-state controls:
//   WAIT : w=1
//   IMM  : write=1, vsel=1, writenum=rd
//   LDA  : readnum=rn, loada=1
//   LDB  : readnum=rm, loadb=1
//   EXEC : shift=cmd shift, bsel=0, loadc=1 unless CMP
//          MOV : asel=1, ALUop=00, loads=0
//          ADD : asel=0, ALUop=00, loads=1
//          CMP : asel=0, ALUop=01, loads=1
//          AND : asel=0, ALUop=10, loads=1
//          MVN : asel=0, ALUop=11, loads=1
//   WB   : write=1, vsel=0, writenum=rd
//   ERR  : err=1
//  Sequences (all return to WAIT); w is low for N cycles:
//   MOVI    IMM                 N=1
//   MOV     LDB,EXEC,WB         N=3
//   ADD,AND LDA,LDB,EXEC,WB     N=4
//   CMP     LDA,LDB,EXEC        N=3, no write
//   MVN     LDB,EXEC,WB         N=3
//   11x     ERR                 N=1, no datapath side effect
//  Back-to-back: s held high in WAIT starts the next command on the very next edge.
//   The minimum gap is one WAIT cycle.
//  rd==rn==rm is legal; the operand reads precede the WB write by construction.
//  datapath_in is only driven from latched imm. It is held until the next accept or reset.
// TESTING
//  T1 reset asserted mid-ADD (in LDB) -> next cycle WAIT, w=1, all controls 0, R unchanged.
//  T2 MOVI rd=0 imm=8'h07, then MOVI rd=1 imm=8'h02 -> IMM pulses write/vsel; R0=7, R1=2.
//  T3 ADD rd=2 rn=1 rm=0 shift=01 (after T2) -> LDA/LDB/EXEC/WB order, w low 4 cycles; R2=16.
//     Check: datapath_out=0010, status=0.
//  T4 CMP rn=0 rm=0 -> loads=1 in EXEC, write never 1, status=1; R regs unchanged.
//  T5 MVN rd=3 rm=0 (R0=7) -> R3=16'hFFF8.
//     MOV rd=4 rm=0 shift=00 -> R4=7, loads=0 throughout.
//  T6 op=3'b110 -> err high 1 cycle, no load/write. s pulses during a busy MOV are ignored.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Command sequencer for the register-file datapath: accepts one command per start
// handshake and steps the datapath control lines through LDA/LDB/EXEC/WB-style phases.
module datapath_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMM_W  = 8,
   parameter int unsigned RN_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [2:0]        op,
   input  logic [RN_W-1:0]   rd,
   input  logic [RN_W-1:0]   rn,
   input  logic [RN_W-1:0]   rm,
   input  logic [1:0]        shift_in,
   input  logic [IMM_W-1:0]  imm,
   output logic              w,
   output logic              err,
   output logic [RN_W-1:0]   readnum,
   output logic [RN_W-1:0]   writenum,
   output logic              loada,
   output logic              loadb,
   output logic              asel,
   output logic              bsel,
   output logic              loadc,
   output logic              loads,
   output logic              write,
   output logic              vsel,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic [DATA_W-1:0] datapath_in
);

   typedef enum logic [2:0] {StWait, StImm, StLda, StLdb, StExec, StWb, StErr} state_e;

   localparam logic [2:0] OpMovi = 3'b000;
   localparam logic [2:0] OpMov  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpCmp  = 3'b011;
   localparam logic [2:0] OpAnd  = 3'b100;
   localparam logic [2:0] OpMvn  = 3'b101;

   state_e            state_q, state_d;
   logic [2:0]        op_q;
   logic [RN_W-1:0]   rd_q, rn_q, rm_q;
   logic [1:0]        shift_q;
   logic [IMM_W-1:0]  imm_q;
   logic              accept;

   assign accept = (state_q == StWait) && s;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StWait;
         op_q    <= '0;
         rd_q    <= '0;
         rn_q    <= '0;
         rm_q    <= '0;
         shift_q <= '0;
         imm_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            shift_q <= shift_in;
            imm_q   <= imm;
         end
      end
   end

   // The first phase is chosen from the live op at accept; later phases use the latched op.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StWait: begin
            if (s) begin
               case (op)
                  OpMovi:               state_d = StImm;
                  OpMov, OpMvn:         state_d = StLdb;
                  OpAdd, OpCmp, OpAnd:  state_d = StLda;
                  default:              state_d = StErr;
               endcase
            end
         end
         StLda:  state_d = StLdb;
         StLdb:  state_d = StExec;
         StExec: state_d = (op_q == OpCmp) ? StWait : StWb;
         default: state_d = StWait;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      err      = 1'b0;
      readnum  = '0;
      writenum = '0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      vsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      unique case (state_q)
         StWait: w = 1'b1;
         StImm: begin
            write    = 1'b1;
            vsel     = 1'b1;
            writenum = rd_q;
         end
         StLda: begin
            readnum = rn_q;
            loada   = 1'b1;
         end
         StLdb: begin
            readnum = rm_q;
            loadb   = 1'b1;
         end
         StExec: begin
            shift = shift_q;
            loadc = (op_q != OpCmp);
            loads = (op_q != OpMov);
            asel  = (op_q == OpMov);
            case (op_q)
               OpCmp:   ALUop = 2'b01;
               OpAnd:   ALUop = 2'b10;
               OpMvn:   ALUop = 2'b11;
               default: ALUop = 2'b00;
            endcase
         end
         StWb: begin
            write    = 1'b1;
            writenum = rd_q;
         end
         StErr: err = 1'b1;
         default: ;
      endcase
   end

   assign datapath_in = DATA_W'(imm_q);

endmodule
